alu_issue: RTL
==============

// Module: alu_issue
// PURPOSE
//   Initiator side of the ALU: accepts one ALU instruction at a time (valid/ready), reads operands
//   through a single register-file read port, drives opcode/in1/in2 into the combinational alu,
//   captures out/carry/zero, then writes back the result and updates the architectural flags.
//   Sits between decode and the register file in the execute stage.
// PARAMETERS
//   REG_AW  5   register index width (2**REG_AW registers)
//   DATA_W  32  datapath width; must be 32 (alu operand width)
// PORTS
//   clk         in   1       clock; all state changes on rising edge
//   rst         in   1       synchronous, active-high reset
//   req_valid   in   1       instruction request valid
//   req_ready   out  1       high only in IDLE
//   req_op      in   4       alu opcode (1 add,2 sub,3 shl,4 shr,5 sar,6 and,7 or,8 xor,9 not)
//   req_rd      in   REG_AW  destination register
//   req_rs1     in   REG_AW  source 1 register
//   req_rs2     in   REG_AW  source 2 register (ignored when req_use_imm)
//   req_use_imm in   1       1: in2 = req_imm
//   req_imm     in   DATA_W  immediate operand
//   rf_raddr    out  REG_AW  register-file read address (read data combinational, same cycle)
//   rf_rdata    in   DATA_W  register-file read data
//   rf_we       out  1       register-file write enable (1-cycle pulse)
//   rf_waddr    out  REG_AW  write address
//   rf_wdata    out  DATA_W  write data
//   alu_opcode  out  4       to alu opcode
//   alu_in1     out  DATA_W  to alu in1
//   alu_in2     out  DATA_W  to alu in2
//   alu_out     in   DATA_W  from alu out
//   alu_carry   in   1       from alu carry
//   alu_zero    in   1       from alu zero
//   flag_carry  out  1       architectural carry flag (registered)
//   flag_zero   out  1       architectural zero flag (registered)
//   done        out  1       1-cycle pulse in WB: instruction retired
// BEHAVIOUR
//   Reset: state=IDLE; req_ready=1 after reset cycle; rf_we=0, done=0, flag_carry=0, flag_zero=0,
//     all address/data/alu outputs 0. Reset mid-operation drops the in-flight op: no write, no done.
//   FSM IDLE->RS1->RS2->EXEC->WB->IDLE. Accept when req_valid&&req_ready in IDLE; latch op/rd/rs*/imm.
//   RS1: rf_raddr=rs1, op1<=rf_rdata. RS2: rf_raddr=rs2, op2<=rf_rdata; skipped when use_imm (op2=imm
//     latched at accept, RS1->EXEC). rf_raddr=0 in IDLE/EXEC/WB.
//   EXEC: alu_opcode=op, alu_in1=op1, alu_in2=op2 (held only in EXEC, 0 otherwise); capture
//     alu_out/carry/zero into result regs at edge.
//   WB: rf_we=1, rf_waddr=rd, rf_wdata=result; flags<=captured carry/zero; done=1.
//   Latency accept-edge T -> done cycle: T+4 register form, T+3 immediate form. Throughput 1 op / 5 (4).
//   rd==0: rf_we suppressed, flags and done still update.
//   Opcode 0 or 10..15: executed as NOP: no write, flags unchanged, done still pulses.
//   Operands passed full 32-bit; shift-amount interpretation belongs to alu.
//   req_* ignored outside IDLE; next accept possible the cycle after WB, which sees the WB write.
// CONFIGURATION
//   ALU_ISSUE_SAMEREG_EN defined: register form with rs1==rs2 skips RS2, op2=op1 (latency T+3).
//   Not defined: RS2 always performed for register form (latency T+4).
// STRUCTURE
//   Shared package alu_pkg: opcode localparams (ALU_ADD..ALU_NOT), opcode-valid function, FSM state
//     typedef/encoding. alu stays external (instantiated by parent). Single module; no sub-module.
// TESTING
//   r1=5,r2=7; add rd=3 -> r3=12, carry=0, zero=0, done at T+4, req_ready low T+1..T+4.
//   r1=0xFFFFFFFF, sub imm=0xFFFFFFFF rd=4 -> r4=0, zero=1, carry=0, done at T+3.
//   r1=0xFFFFFFFF,r2=1 add rd=0 -> rf_we never 1, flag_carry=1, flag_zero=1, done pulses.
//   opcode 0xC after flags set -> no rf_we, flags unchanged, done pulses at T+4.
//   rst asserted in EXEC -> no rf_we, no done, flags 0, req_ready=1 next cycle.
//   rs1=rs2=2 (r2=3), add -> r=6; done T+3 with ALU_ISSUE_SAMEREG_EN, T+4 without.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue path.
//   - Opcode constants ALU_ADD..ALU_NOT as understood by the external alu.
//   - op_valid(): opcodes outside 1..9 retire as NOPs.
//   - FSM state type and encoding used by alu_issue.
`timescale 1ns/1ps
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_SHL = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_SAR = 4'd5;
    localparam logic [3:0] ALU_AND = 4'd6;
    localparam logic [3:0] ALU_OR  = 4'd7;
    localparam logic [3:0] ALU_XOR = 4'd8;
    localparam logic [3:0] ALU_NOT = 4'd9;

    function automatic logic op_valid(input logic [3:0] op);
        return (op >= ALU_ADD) && (op <= ALU_NOT);
    endfunction

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_RS1  = 3'd1;
    localparam state_t S_RS2  = 3'd2;
    localparam state_t S_EXEC = 3'd3;
    localparam state_t S_WB   = 3'd4;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction request bundle from decode to alu_issue.
//   req_valid/req_ready handshake plus the instruction fields
//   (req_op, req_rd, req_rs1, req_rs2, req_use_imm, req_imm).
//   master: decode side (drives request, sees ready).
//   slave : alu_issue side (sees request, drives ready).
`timescale 1ns/1ps
interface alu_issue_if #(
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [REG_AW-1:0] req_rd;
    logic [REG_AW-1:0] req_rs1;
    logic [REG_AW-1:0] req_rs2;
    logic              req_use_imm;
    logic [DATA_W-1:0] req_imm;

    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2, req_use_imm, req_imm,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_use_imm, req_imm,
        output req_ready
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: execute-stage initiator for the combinational alu.
//   Accepts one instruction at a time, reads rs1 (and rs2 unless the
//   immediate form is used) through a single register-file read port,
//   presents the operands to the alu for one cycle, captures the result,
//   then writes back and updates the architectural flags.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   issue (slave)       request handshake and instruction fields
//   rf_raddr / rf_rdata register-file read port (combinational read)
//   rf_we/waddr/wdata   register-file write port (1-cycle pulse in WB)
//   alu_opcode/in1/in2  operands to alu (non-zero only in EXEC)
//   alu_out/carry/zero  results from alu
//   flag_carry/zero     architectural flags
//   done                1-cycle pulse when an instruction retires
// Configuration:
//   ALU_ISSUE_SAMEREG_EN  when defined, a register-form instruction with
//                         rs1 == rs2 skips the second read (op2 = op1).
`timescale 1ns/1ps
module alu_issue
    import alu_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_if.slave        issue,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              flag_carry,
    output logic              flag_zero,
    output logic              done
);

    state_t            state;
    logic [3:0]        op_r;
    logic [REG_AW-1:0] rd_r;
    logic [REG_AW-1:0] rs1_r;
    logic [REG_AW-1:0] rs2_r;
    logic              use_imm_r;
    logic [DATA_W-1:0] op1_r;
    logic [DATA_W-1:0] op2_r;
    logic [DATA_W-1:0] res_r;
    logic              carry_r;
    logic              zero_r;
    logic              skip_rs2;

`ifdef ALU_ISSUE_SAMEREG_EN
    assign skip_rs2 = use_imm_r || (rs1_r == rs2_r);
`else
    assign skip_rs2 = use_imm_r;
`endif

    // Control: state and architectural flags (the only reset state).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            flag_carry <= 1'b0;
            flag_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (issue.req_valid) state <= S_RS1;
                S_RS1:  state <= skip_rs2 ? S_EXEC : S_RS2;
                S_RS2:  state <= S_EXEC;
                S_EXEC: state <= S_WB;
                S_WB: begin
                    if (op_valid(op_r)) begin
                        flag_carry <= carry_r;
                        flag_zero  <= zero_r;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: instruction fields, operands and captured result.
    // None of these are visible outside the states that qualify them,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (issue.req_valid) begin
                op_r      <= issue.req_op;
                rd_r      <= issue.req_rd;
                rs1_r     <= issue.req_rs1;
                rs2_r     <= issue.req_rs2;
                use_imm_r <= issue.req_use_imm;
                op2_r     <= issue.req_imm;
            end
            S_RS1: begin
                op1_r <= rf_rdata;
                // Preload op2 with op1 so the same-register shortcut needs
                // no extra read; overwritten in RS2 when RS2 is performed.
                if (!use_imm_r) op2_r <= rf_rdata;
            end
            S_RS2:  op2_r <= rf_rdata;
            S_EXEC: begin
                res_r   <= alu_out;
                carry_r <= alu_carry;
                zero_r  <= alu_zero;
            end
            default: ;
        endcase
    end

    always_comb begin
        issue.req_ready = (state == S_IDLE);
        rf_raddr   = '0;
        alu_opcode = '0;
        alu_in1    = '0;
        alu_in2    = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        done       = 1'b0;
        case (state)
            S_RS1: rf_raddr = rs1_r;
            S_RS2: rf_raddr = rs2_r;
            S_EXEC: begin
                alu_opcode = op_r;
                alu_in1    = op1_r;
                alu_in2    = op2_r;
            end
            S_WB: begin
                // r0 is never written; invalid opcodes retire as NOPs.
                rf_we    = op_valid(op_r) && (rd_r != '0);
                rf_waddr = rd_r;
                rf_wdata = res_r;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
